// File: rtl/sevenseg_if.sv
// Board-side bundle for the seven-segment scan driver: nibble/blanking inputs
// in, segment bus, digit enables and nibble sum out.
interface sevenseg_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int SUM_W = 4 + $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] digits_i;
  logic                    blank_lz_i;
  logic [6:0]              seg_o;
  logic [NUM_DIGITS-1:0]   enable_o;
  logic [SUM_W-1:0]        sum_o;

  modport master (
    output digits_i, blank_lz_i,
    input  seg_o, enable_o, sum_o
  );

  modport slave (
    input  digits_i, blank_lz_i,
    output seg_o, enable_o, sum_o
  );
endinterface

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed seven-segment driver: scans synchronized hex nibbles onto an
// active-low segment bus with dead-time blanking and optional leading-zero blanking.
module sevenseg_scan_mux #(
  parameter int NUM_DIGITS   = 2,
  parameter int DIV_COUNT    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  sevenseg_if.slave  bus
);
  localparam int SUM_W = 4 + $clog2(NUM_DIGITS);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(DIV_COUNT);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [DW:0]             sync1_q, sync2_q;
  logic [DW-1:0]           ds_s;
  logic                    lz_s;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [3:0]              cur_nib_s;
  logic                    upper_nz_s;
  logic                    suppress_s;
  logic                    in_blank_s;
  logic [0:0]              slot_state_s;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      4'hF:    code = 7'b0001110;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  assign ds_s = sync2_q[DW-1:0];
  assign lz_s = sync2_q[DW];

  // Slot counter and digit index advance
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Nibble sum, current nibble select and "anything nonzero at or above idx"
  always_comb begin
    sum_d      = '0;
    cur_nib_s  = 4'h0;
    upper_nz_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sum_d      = sum_d + SUM_W'(ds_s[4*i +: 4]);
      cur_nib_s  = (IDX_W'(i) == idx_q) ? ds_s[4*i +: 4] : cur_nib_s;
      upper_nz_s = upper_nz_s | ((IDX_W'(i) >= idx_q) && (ds_s[4*i +: 4] != 4'h0));
    end
  end

  // With zero dead-time the comparison would be constant-false, so drop it
  if (BLANK_CYCLES > 0) begin : g_blank
    assign in_blank_s = (cnt_q < CNT_W'(BLANK_CYCLES));
  end else begin : g_noblank
    assign in_blank_s = 1'b0;
  end

  assign suppress_s   = lz_s && (idx_q != '0) && !upper_nz_s;
  assign slot_state_s = (in_blank_s || suppress_s) ? ST_BLANK : ST_DRIVE;

  // Segment/enable next values for the current slot state
  always_comb begin
    case (slot_state_s)
      ST_DRIVE: begin
        seg_d = hex7(cur_nib_s);
        en_d  = ~(NUM_DIGITS'(1) << idx_q);
      end
      default: begin
        seg_d = 7'h7F;
        en_d  = '1;
      end
    endcase
  end

  // All state: synchronizer, scan counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      seg_q   <= 7'h7F;
      en_q    <= '1;
    end else begin
      sync1_q <= {bus.blank_lz_i, bus.digits_i};
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign bus.seg_o    = seg_q;
  assign bus.enable_o = en_q;
  assign bus.sum_o    = sum_q;
endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Bench for sevenseg_scan_mux: a 4-digit and a 1-digit instance share clock and
// reset and are compared every cycle against a slot-arithmetic reference model.
module tb_sevenseg_scan_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   c          = 0;

  logic [15:0] cur_d;
  logic        cur_lz;
  logic [15:0] hist_d [0:4095];
  logic        hist_l [0:4095];
  logic [6:0]  glyph  [0:15];

  int         chk_sum_c = -1;
  logic [5:0] chk_sum_v;
  int         chk_en_c  = -1;
  logic [3:0] chk_en_v;
  logic [3:0] watch_mask = 4'b0000;
  logic       hi_low_seen = 1'b0;

  sevenseg_if #(.NUM_DIGITS(4)) ifa ();
  sevenseg_if #(.NUM_DIGITS(1)) ifb ();

  sevenseg_scan_mux #(.NUM_DIGITS(4), .DIV_COUNT(10), .BLANK_CYCLES(2)) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .bus(ifa)
  );
  sevenseg_scan_mux #(.NUM_DIGITS(1), .DIV_COUNT(4), .BLANK_CYCLES(0)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .bus(ifb)
  );

  // Outputs in cycle cyc reflect the slot position cyc-1 and the nibbles that
  // entered the pins two cycles before that.
  function automatic void model(input int n, input int div, input int blk, input int cyc,
                                output logic [6:0] s, output logic [7:0] e,
                                output logic [7:0] sm);
    int          p, off, idx;
    logic [31:0] ds;
    logic        lz;
    s  = 7'h7F;
    e  = 8'hFF;
    sm = 8'h00;
    if (cyc >= 1) begin
      p  = cyc - 1;
      ds = 32'h0;
      lz = 1'b0;
      if (p >= 2) begin
        ds = {16'h0, hist_d[p-2]};
        lz = hist_l[p-2];
      end
      if (n == 1) ds = ds & 32'hF;
      for (int i = 0; i < n; i++) sm = sm + 8'((ds >> (4*i)) & 32'hF);
      off = p % div;
      idx = (p / div) % n;
      if (off >= blk && !(lz && idx > 0 && (ds >> (4*idx)) == 32'h0)) begin
        s = glyph[int'((ds >> (4*idx)) & 32'hF)];
        e = ~(8'h01 << idx);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic check_cycle(input bit rst_exp);
    logic [6:0] sa, sb;
    logic [7:0] ea, eb, ma, mb;
    if (rst_exp) begin
      sa = 7'h7F; ea = 8'hFF; ma = 8'h00;
      sb = 7'h7F; eb = 8'hFF; mb = 8'h00;
    end else begin
      model(4, 10, 2, c, sa, ea, ma);
      model(1, 4, 0, c, sb, eb, mb);
    end
    @(negedge clk);
    chk("segA", 32'(ifa.seg_o), 32'(sa));
    chk("enA", 32'(ifa.enable_o), 32'(ea[3:0]));
    chk("sumA", 32'(ifa.sum_o), 32'(ma[5:0]));
    chk("segB", 32'(ifb.seg_o), 32'(sb));
    chk("enB", 32'(ifb.enable_o), 32'(eb[0]));
    chk("sumB", 32'(ifb.sum_o), 32'(mb[3:0]));
    if (!rst_exp && c == chk_en_c) chk("enA_directed", 32'(ifa.enable_o), 32'(chk_en_v));
    if (!rst_exp && c == chk_sum_c) chk("sumA_directed", 32'(ifa.sum_o), 32'(chk_sum_v));
    if ((~ifa.enable_o & watch_mask) != 4'b0000) hi_low_seen = 1'b1;
  endtask

  task automatic step(input bit rst_exp, input bit skip);
    if (c < 4096) begin
      hist_d[c] = cur_d;
      hist_l[c] = cur_lz;
    end
    ifa.digits_i   = cur_d;
    ifa.blank_lz_i = cur_lz;
    ifb.digits_i   = cur_d[3:0];
    ifb.blank_lz_i = cur_lz;
    if (skip) @(negedge clk);
    else check_cycle(rst_exp);
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run(input int n, input bit rnd);
    int k;
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 4) == 0) begin
        k      = $urandom_range(0, 4);
        cur_d  = 16'($urandom) & (16'hFFFF >> (4*k));
        cur_lz = 1'($urandom_range(0, 1));
      end
      step(1'b0, 1'b0);
    end
  endtask

  task automatic reset_seq(input int k);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 1; i < k; i++) step(1'b1, 1'b0);
    rst_n = 1'b1;
    c = 0;
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n  = 1'b0;
    cur_d  = 16'hFFFF;
    cur_lz = 1'b0;

    // power-up: first cycle is unknown, then three cycles under reset
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rst_n    = 1'b1;
    c        = 0;
    chk_en_c = 3;
    chk_en_v = 4'b1110;
    run(12, 1'b0);

    // scan order with four distinct glyphs
    cur_d = 16'h1A80;
    run(90, 1'b0);

    // sum latency, full-scale and back to zero
    cur_d     = 16'hFFFF;
    chk_sum_c = c + 3;
    chk_sum_v = 6'd60;
    run(6, 1'b0);
    cur_d     = 16'h0000;
    chk_sum_c = c + 3;
    chk_sum_v = 6'd0;
    run(6, 1'b0);
    chk_sum_c = -1;

    // leading-zero blanking
    cur_lz = 1'b1;
    cur_d  = 16'h0050;
    run(4, 1'b0);
    watch_mask  = 4'b1100;
    hi_low_seen = 1'b0;
    run(80, 1'b0);
    chk("lz_0050_high_digits_dark", 32'(hi_low_seen), 32'd0);
    cur_d = 16'h0000;
    run(4, 1'b0);
    watch_mask  = 4'b1110;
    hi_low_seen = 1'b0;
    run(80, 1'b0);
    chk("lz_zero_only_digit0", 32'(hi_low_seen), 32'd0);
    watch_mask = 4'b0000;

    // randomized nibbles with random leading zeros and blanking mode
    run(400, 1'b1);

    // reset during DRIVE of digit 2
    cur_d  = 16'h1A80;
    cur_lz = 1'b0;
    for (int i = 0; i < 40 && (c % 40) != 25; i++) step(1'b0, 1'b0);
    chk("midscan_phase", 32'(c % 40), 32'd25);
    reset_seq(2);
    chk_en_c = 3;
    chk_en_v = 4'b1110;
    run(50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_mux.md
# sevenseg_scan_mux

Parametrised time-multiplexed seven-segment display driver. It scans NUM_DIGITS hex nibbles onto a shared active-low segment bus with per-digit active-low enables. A blanking dead-time at each digit switch suppresses ghosting, and optional leading-zero blanking hides unused high digits. It also outputs a registered sum of all synchronized nibbles for the LED bar, and sits between the board switch/data inputs and the display/LED pins.

## Interface
- NUM_DIGITS, 2: number of digits scanned; legal range 1..8.
- DIV_COUNT, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: dead-time cycles at the start of each slot; must satisfy 0 ≤ BLANK_CYCLES < DIV_COUNT.
- SUM_W, 4+$clog2(NUM_DIGITS): sum width, derived; not overridden.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- digits  in  4*NUM_DIGITS  nibble i = digits[4i+3:4i]; digit 0 is the rightmost (least significant). Asynchronous to clk.
- blank_lz  in  1  1 = leading-zero blanking enabled. Synchronized together with digits.
- seg  out  7  {g,f,e,d,c,b,a}, active-low (0 = segment lit).
- enable  out  NUM_DIGITS  per-digit enable, active-low; at most one bit is 0 at any time.
- sum  out  SUM_W  unsigned sum of all synchronized nibbles.

## Operation
- Input sync:
  - Two-flop synchronizer on {blank_lz, digits}.
  - All logic uses the stage-2 value (ds).
- Sum:
  - sum <= Σ ds nibble i, zero-extended to SUM_W; registered every cycle.
  - No overflow is possible (max 15·NUM_DIGITS fits in SUM_W).
- Slot counter cnt:
  - Counts 0..DIV_COUNT-1.
  - At DIV_COUNT-1, cnt wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
  - When NUM_DIGITS = 1, idx stays 0.
- Slot states, decoded from cnt:
  - BLANK (cnt < BLANK_CYCLES): enable = all 1s, seg = 7'h7F.
  - DRIVE (cnt ≥ BLANK_CYCLES): enable[idx] = 0, all other enable bits = 1, seg = hex decode of ds nibble idx.
  - When BLANK_CYCLES = 0, there is no BLANK state; DRIVE slots are back-to-back.
- Leading-zero blanking (blank_lz = 1):
  - Digit i > 0 is suppressed when nibble i and every nibble above it are 0.
  - A suppressed digit's DRIVE behaves as BLANK: enable all 1s, seg 7'h7F.
  - Digit 0 is never suppressed.
- Hex decode: standard 0–F glyphs, lower-case b and d. Required codes:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - b → 7'b0000011
  - F → 7'b0001110
- Reset (reset = 0 at a rising edge):
  - cnt = 0, idx = 0.
  - Sync registers = 0, sum = 0.
  - seg = 7'h7F, enable = all 1s.
  - Reset wins over every other event, including mid-slot or at wrap; scanning always restarts at digit 0 in BLANK.

## Timing
- Cycle numbering: cycle 0 is the first cycle after the edge that samples reset = 1. cnt = 0, idx = 0 in cycle 0.
- seg/enable are registered from (cnt, idx, ds) with 1-cycle latency.
- enable[0] first goes low in cycle BLANK_CYCLES+1.
- Each digit is lit for DIV_COUNT-BLANK_CYCLES cycles; the full scan period is NUM_DIGITS·DIV_COUNT cycles.
- digits change → sum updates 3 cycles later (2 sync stages + 1 register).
- digits change → seg updates 3 cycles later, if that digit is in DRIVE.
- A change mid-DRIVE takes effect immediately at that latency; there is no slot-boundary latching.
- blank_lz change → effect on enable after 3 cycles.
- No handshakes; outputs are glitch-free because they are registered.

## Test plan
Parameters for tests 1–5: NUM_DIGITS=4, DIV_COUNT=10, BLANK_CYCLES=2.
- Reset: hold reset = 0 for 3 cycles with digits = 16'hFFFF.
  - Required: seg = 7F, enable = 4'hF, sum = 0 every cycle.
  - After release, enable stays 4'hF through cycle 2; enable = 4'b1110 from cycle 3.
- Scan order: digits = 16'h1A80, blank_lz = 0.
  - Enable sequence 1110 → 1101 → 1011 → 0111; each low for 8 cycles, separated by 2 cycles of 1111; period 40 cycles.
  - seg during each digit: 1000000, 0000000, 0001000, 1111001.
- Sum: digits = 16'hFFFF → sum = 60 exactly 3 cycles later; then digits = 16'h0000 → sum = 0 three cycles later.
- Leading-zero blanking: blank_lz = 1.
  - digits = 16'h0050: enable[3] and enable[2] never go low; digit 1 shows 5 (7'b0010010), digit 0 shows 0.
  - digits = 0: only enable[0] ever goes low.
- Reset mid-scan: assert reset during DRIVE of idx = 2.
  - Next edge gives seg = 7F, enable = F.
  - After release, the first lit digit is digit 0, in cycle 3.
- Edge parameters: NUM_DIGITS=1, DIV_COUNT=4, BLANK_CYCLES=0.
  - enable is constantly 0 from cycle 1; seg tracks nibble 0.
  - sum equals nibble 0 (4 bits).
